// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared types and glyph tables for the seven-segment scan
//               driver. Glyphs are 7-bit {g,f,e,d,c,b,a}, active-low.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    typedef enum logic {
        GLYPH_HEX  = 1'b0,
        GLYPH_NOTE = 1'b1
    } glyph_mode_e;

    localparam logic [6:0] SSD_BLANK = 7'h7F;
    localparam logic [6:0] SSD_DASH  = 7'h3F;

    // Standard hexadecimal digits 0..F
    localparam logic [6:0] HEX_GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Note names for codes 0..A: A, Bb, B, C, C#, D, Eb, F, F#, G, G#
    localparam logic [6:0] NOTE_GLYPHS [11] = '{
        7'h08, 7'h43, 7'h03, 7'h46, 7'h44, 7'h21,
        7'h06, 7'h0E, 7'h0C, 7'h02, 7'h00
    };

endpackage
`default_nettype wire

// File: rtl/ssd_glyph.sv
`default_nettype none
// ============================================================================
// Module      : ssd_glyph
// Description : Combinational nibble-to-glyph lookup for one digit.
//   i_nibble : 4-bit digit code
//   i_mode   : glyph set (hex or note name)
//   o_seg    : 7-bit segment pattern {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_glyph
    import ssd_pkg::*;
(
    input  logic [3:0]  i_nibble,
    input  glyph_mode_e i_mode,
    output logic [6:0]  o_seg
);

    always_comb begin
        o_seg = SSD_BLANK;
        if (i_mode == GLYPH_HEX) begin
            o_seg = HEX_GLYPHS[i_nibble];
        end else if (i_nibble <= 4'hA) begin
            o_seg = NOTE_GLYPHS[i_nibble];
        end else if (i_nibble == 4'hB) begin
            o_seg = SSD_DASH;
        end
        // note codes C..F stay blank
    end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_driver
// Description : Time-multiplexed driver for an N-digit common-anode seven-
//               segment display. One digit per slot, all anodes off for the
//               first GUARD cycles of each slot, per-digit blank/blink, and a
//               valid/ready load port whose contents take effect at a frame
//               boundary.
//   clk_i / reset_i        : clock, asynchronous active-high reset
//   load_valid_i/ready_o   : load handshake; ready while pending buffer empty
//   mode_i, digits_i,
//   blank_i, blink_i, dp_i : display contents, captured on accept
//   ssd_o, dp_o, an_o      : registered, active-low pin drives
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1024,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 256
)(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    input  logic                    mode_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [6:0]              ssd_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o
);

    localparam int c_idx_w   = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int c_slot_w  = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int c_frame_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_slot_w-1:0]   c_slot_last  = c_slot_w'(SCAN_DIV - 1);
    localparam logic [c_slot_w-1:0]   c_guard      = c_slot_w'(GUARD);
    localparam logic [c_idx_w-1:0]    c_idx_last   = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_frame_w-1:0]  c_frame_last = c_frame_w'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0] c_an_one     = NUM_DIGITS'(1);

    // pending buffer
    logic                    r_pend_full;
    logic [4*NUM_DIGITS-1:0] r_pend_digits;
    glyph_mode_e             r_pend_mode;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic [NUM_DIGITS-1:0]   r_pend_blink;
    logic [NUM_DIGITS-1:0]   r_pend_dp;

    // active (displayed) contents
    logic [4*NUM_DIGITS-1:0] r_act_digits;
    glyph_mode_e             r_act_mode;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [NUM_DIGITS-1:0]   r_act_blink;
    logic [NUM_DIGITS-1:0]   r_act_dp;

    // scan state
    logic [c_slot_w-1:0]     r_slot;
    logic [c_idx_w-1:0]      r_idx;
    logic [c_frame_w-1:0]    r_frame;
    logic                    r_blink_phase;

    // output registers
    logic [6:0]              r_ssd;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_accept;
    logic                    w_boundary;
    logic                    w_visible;
    logic [3:0]              w_nibble;
    logic [6:0]              w_glyph;
    logic [NUM_DIGITS-1:0]   w_an_sel;

    assign w_accept   = load_valid_i & ~r_pend_full;
    assign w_boundary = (r_slot == c_slot_last) && (r_idx == c_idx_last);
    assign w_nibble   = r_act_digits[{r_idx, 2'b00} +: 4];
    assign w_an_sel   = ~(c_an_one << r_idx);
    assign w_visible  = (r_slot >= c_guard) && !r_act_blank[r_idx]
                        && !(r_act_blink[r_idx] && r_blink_phase);

    ssd_glyph u_glyph (
        .i_nibble (w_nibble),
        .i_mode   (r_act_mode),
        .o_seg    (w_glyph)
    );

    // Scan counters: slot within digit, digit index, frame count, blink phase
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_slot        <= '0;
            r_idx         <= '0;
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (r_slot == c_slot_last) begin
                r_slot <= '0;
                r_idx  <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_slot <= r_slot + 1'b1;
            end
            if (w_boundary) begin
                if (r_frame == c_frame_last) begin
                    r_frame       <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end
        end
    end

    // Load path. Acceptance implies the pending buffer is empty, so a boundary
    // either drains pending or, if a load lands on it, takes the input direct.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_pend_full   <= 1'b0;
            r_pend_digits <= '0;
            r_pend_mode   <= GLYPH_HEX;
            r_pend_blank  <= '0;
            r_pend_blink  <= '0;
            r_pend_dp     <= '0;
            r_act_digits  <= '0;
            r_act_mode    <= GLYPH_HEX;
            r_act_blank   <= '1;
            r_act_blink   <= '0;
            r_act_dp      <= '0;
        end else if (w_boundary && r_pend_full) begin
            r_act_digits <= r_pend_digits;
            r_act_mode   <= r_pend_mode;
            r_act_blank  <= r_pend_blank;
            r_act_blink  <= r_pend_blink;
            r_act_dp     <= r_pend_dp;
            r_pend_full  <= 1'b0;
        end else if (w_accept && w_boundary) begin
            r_act_digits <= digits_i;
            r_act_mode   <= glyph_mode_e'(mode_i);
            r_act_blank  <= blank_i;
            r_act_blink  <= blink_i;
            r_act_dp     <= dp_i;
        end else if (w_accept) begin
            r_pend_digits <= digits_i;
            r_pend_mode   <= glyph_mode_e'(mode_i);
            r_pend_blank  <= blank_i;
            r_pend_blink  <= blink_i;
            r_pend_dp     <= dp_i;
            r_pend_full   <= 1'b1;
        end
    end

    // Registered pin drives, one cycle behind the scan state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_ssd <= SSD_BLANK;
            r_dp  <= 1'b1;
            r_an  <= '1;
        end else if (w_visible) begin
            r_ssd <= w_glyph;
            r_dp  <= ~r_act_dp[r_idx];
            r_an  <= w_an_sel;
        end else begin
            r_ssd <= SSD_BLANK;
            r_dp  <= 1'b1;
            r_an  <= '1;
        end
    end

    assign load_ready_o = ~r_pend_full;
    assign ssd_o        = r_ssd;
    assign dp_o         = r_dp;
    assign an_o         = r_an;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_driver
// Description : Scoreboard bench for ssd_scan_driver with NUM_DIGITS=4,
//               SCAN_DIV=8, GUARD=1, BLINK_FRAMES=2 (32-cycle frames).
//               Expected pin values are queued per cycle by the stimulus and
//               compared by an independent monitor on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_driver;

    localparam int NUM_DIGITS   = 4;
    localparam int SCAN_DIV     = 8;
    localparam int GUARD        = 1;
    localparam int BLINK_FRAMES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        mode = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  blink = '0;
    logic [3:0]  dp = '0;
    logic [6:0]  ssd;
    logic        dp_pin;
    logic [3:0]  an;

    ssd_scan_driver #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .GUARD        (GUARD),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .load_valid_i (load_valid),
        .load_ready_o (load_ready),
        .mode_i       (mode),
        .digits_i     (digits),
        .blank_i      (blank),
        .blink_i      (blink),
        .dp_i         (dp),
        .ssd_o        (ssd),
        .dp_o         (dp_pin),
        .an_o         (an)
    );

    always #5 clk = ~clk;

    // free-running count of rising edges; at a falling edge it equals the
    // number of edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         is_rdy;
        logic [3:0] an;
        logic [6:0] ssd;
        logic       dp;
        logic       rdy;
        int         sc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   base     = 0;

    function automatic void push_disp(int c, logic [3:0] a, logic [6:0] s, logic d, int sc);
        exp_t e;
        e.cyc = c; e.is_rdy = 1'b0; e.an = a; e.ssd = s; e.dp = d; e.rdy = 1'b0; e.sc = sc;
        sb.push_back(e);
    endfunction

    function automatic void push_rdy(int c, logic r, int sc);
        exp_t e;
        e.cyc = c; e.is_rdy = 1'b1; e.an = '1; e.ssd = '1; e.dp = 1'b1; e.rdy = r; e.sc = sc;
        sb.push_back(e);
    endfunction

    function automatic void push_dark(int c, int sc);
        push_disp(c, 4'hF, 7'h7F, 1'b1, sc);
    endfunction

    // Frame whose first scan state is f (edges since reset): slot 0 of each
    // digit shows dark one cycle later, slots 1..7 show the glyph.
    function automatic void expect_frame(int f, logic [6:0] g0, logic [6:0] g1,
                                         logic [6:0] g2, logic [6:0] g3,
                                         logic [3:0] dpo, logic [3:0] dark, int sc);
        logic [6:0] g [4];
        logic [3:0] a;
        g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
        for (int d = 0; d < 4; d++) begin
            a = 4'b0001 << d;
            a = ~a;
            push_dark(f + 8*d + 1, sc);
            for (int s = 2; s <= 8; s++) begin
                if (dark[d]) push_dark(f + 8*d + s, sc);
                else         push_disp(f + 8*d + s, a, g[d], dpo[d], sc);
            end
        end
    endfunction

    // Monitor: compare every queued expectation due on this cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                n_checks++;
                if (sb[i].is_rdy) begin
                    if (load_ready === sb[i].rdy) n_pass++;
                    else $display("FAIL rdy s%0d cyc=%0d load_ready got %b exp %b",
                                  sb[i].sc, cyc - base, load_ready, sb[i].rdy);
                end else begin
                    if ({an, ssd, dp_pin} === {sb[i].an, sb[i].ssd, sb[i].dp}) n_pass++;
                    else $display("FAIL disp s%0d cyc=%0d an/ssd/dp got %b/%b/%b exp %b/%b/%b",
                                  sb[i].sc, cyc - base, an, ssd, dp_pin,
                                  sb[i].an, sb[i].ssd, sb[i].dp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Offer one load (called at a falling edge) and hold it until accepted
    task automatic send(input logic [15:0] dg, input logic md, input logic [3:0] bl,
                        input logic [3:0] bk, input logic [3:0] dpv);
        int n;
        n = 0;
        digits = dg; mode = md; blank = bl; blink = bk; dp = dpv;
        load_valid = 1'b1;
        while (!load_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) begin
            n_checks++;
            $display("FAIL send_timeout load_ready got 0 exp 1 within 1000 cycles");
            load_valid = 1'b0;
        end else begin
            @(negedge clk);
            load_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        base = cyc;

        // s1: dark after reset until a load lands
        for (int e = 1; e <= 64; e++) push_dark(base + e, 1);
        push_rdy(base + 1, 1'b1, 1);
        push_rdy(base + 64, 1'b1, 1);
        push_dark(base + 96, 1);

        // s2: note 3210 loaded at state 70, shown from frame 96 (dp on digit 2)
        push_rdy(base + 72, 1'b0, 2);
        push_rdy(base + 97, 1'b1, 2);
        expect_frame(base + 96, 7'h08, 7'h43, 7'h03, 7'h46, 4'b1011, 4'b0000, 2);

        // s3: back-to-back loads, second stalls until first is applied
        push_rdy(base + 134, 1'b0, 3);
        push_rdy(base + 159, 1'b0, 3);
        push_rdy(base + 160, 1'b1, 3);
        push_rdy(base + 161, 1'b0, 3);
        push_rdy(base + 192, 1'b1, 3);
        expect_frame(base + 160, 7'h03, 7'h08, 7'h10, 7'h00, 4'hF, 4'b0000, 3);
        expect_frame(base + 192, 7'h78, 7'h02, 7'h12, 7'h19, 4'hF, 4'b0000, 3);

        // s4: load on the boundary cycle goes straight to the display
        push_rdy(base + 224, 1'b1, 4);
        push_rdy(base + 225, 1'b1, 4);
        expect_frame(base + 224, 7'h46, 7'h21, 7'h06, 7'h0E, 4'hF, 4'b0000, 4);

        // s5: hex ABCD with digit 0 blinking; phase is 1 during states 320..383
        push_rdy(base + 241, 1'b0, 5);
        push_rdy(base + 256, 1'b1, 5);
        expect_frame(base + 256, 7'h21, 7'h46, 7'h03, 7'h08, 4'hF, 4'b0000, 5);
        expect_frame(base + 320, 7'h21, 7'h46, 7'h03, 7'h08, 4'hF, 4'b0001, 5);
        expect_frame(base + 384, 7'h21, 7'h46, 7'h03, 7'h08, 4'hF, 4'b0000, 5);

        wait_until(base + 70);
        send(16'h3210, 1'b1, 4'h0, 4'h0, 4'b0100);
        wait_until(base + 133);
        send(16'h89AB, 1'b0, 4'h0, 4'h0, 4'h0);
        send(16'h4567, 1'b0, 4'h0, 4'h0, 4'h0);
        wait_until(base + 223);
        send(16'hFEDC, 1'b0, 4'h0, 4'h0, 4'h0);
        wait_until(base + 240);
        send(16'hABCD, 1'b0, 4'h0, 4'b0001, 4'h0);

        // s6: reset mid-slot while a load is pending
        wait_until(base + 450);
        push_rdy(base + 452, 1'b0, 6);
        push_disp(base + 458, 4'b1101, 7'h46, 1'b1, 6);
        send(16'h1111, 1'b0, 4'h0, 4'h0, 4'h0);
        wait_until(base + 458);
        #2 rst = 1'b1;
        push_dark(cyc + 1, 6);
        push_rdy(cyc + 1, 1'b1, 6);
        push_dark(cyc + 2, 6);
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        base = cyc;
        for (int e = 1; e <= 64; e++) push_dark(base + e, 6);
        push_rdy(base + 1, 1'b1, 6);
        push_rdy(base + 64, 1'b1, 6);
        wait_until(base + 70);

        // anything still queued was never reached
        foreach (sb[i]) begin
            n_checks++;
            $display("FAIL unchecked s%0d cyc=%0d got pending exp compared", sb[i].sc, sb[i].cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display that generalises the single-digit glyph lookup to a parametrised digit count, with a selectable hex or note-name glyph set. It scans one digit per slot, blanks all anodes for a guard interval to suppress ghosting, and supports per-digit blanking and blinking. New display contents arrive through a valid/ready load port and take effect only at a frame boundary. It sits between the tuner's note/cents logic and the board pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (>= 1)
- SCAN_DIV, 1024, clock cycles per digit slot (> GUARD)
- GUARD, 16, cycles at slot start with all anodes off (>= 0)
- BLINK_FRAMES, 256, frames per blink half-period (>= 1)
- clk_i  in  1  single clock
- reset_i  in  1  asynchronous, active-high reset
- load_valid_i  in  1  new display contents offered
- load_ready_o  out  1  pending buffer empty; load accepted when valid & ready
- mode_i  in  1  glyph set, sampled with load: 0 = hex, 1 = note
- digits_i  in  4*NUM_DIGITS  nibble k drives digit k; digit 0 is rightmost
- blank_i  in  NUM_DIGITS  per-digit force-off, sampled with load
- blink_i  in  NUM_DIGITS  per-digit blink enable, sampled with load
- dp_i  in  NUM_DIGITS  per-digit decimal point, active-high, sampled with load
- ssd_o  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_o  out  1  decimal point, active-low
- an_o  out  NUM_DIGITS  anode enables, active-low

## Operation
- Three register sets:
  - pending: contents + mode + pending_full flag
  - active: what is displayed
  - scan state: slot counter 0..SCAN_DIV-1, digit index 0..NUM_DIGITS-1, frame counter 0..BLINK_FRAMES-1, blink_phase
- load_ready_o = !pending_full. Accept on load_valid_i & load_ready_o. Fields are captured into pending and pending_full is set.
- Frame boundary: slot counter == SCAN_DIV-1 and digit index == NUM_DIGITS-1. At the boundary, if pending_full, pending is copied to active and pending_full is cleared.
- Accept on a boundary cycle: the offered data bypasses pending, is copied straight to active, and pending_full stays 0.
- Index advance: slot counter wraps at SCAN_DIV-1 and the digit index increments, wrapping to 0. Frame counter increments at each boundary and wraps at BLINK_FRAMES-1. blink_phase toggles on that wrap.
- Digit k is visible when: slot counter >= GUARD, !blank[k], and !(blink[k] & blink_phase).
- Glyph, hex mode: standard 0-F.
- Glyph, note mode, codes 0..A: A, Bb, B, C, C#, D, Eb, F, F#, G, G#.
  - Bit patterns: 0001000, 1000011, 0000011, 1000110, 1000100, 0100001, 0000110, 0001110, 0001100, 0000010, 0000000.
  - Code B gives '-' (0111111). Codes C..F are blank (1111111).
- When the current digit is not visible: an_o all ones, ssd_o 7'h7F, dp_o 1.
- When the current digit is visible: an_o has only bit idx low, ssd_o = glyph, dp_o = !dp[idx].

## Timing
- Reset values:
  - ssd_o 7'h7F, dp_o 1, an_o all ones, load_ready_o 1
  - counters 0, blink_phase 0, pending_full 0
  - active digits 0, blank all ones, blink 0, dp 0, mode 0
  - The display is dark until the first load is applied.
- ssd_o, dp_o and an_o are registered and reflect the scan state of the previous cycle (1-cycle latency).
- Load-to-display latency: at most one frame (NUM_DIGITS*SCAN_DIV cycles) plus 1 cycle.
- A load offered while pending_full is 1 is stalled and held by the source. The pending buffer is never overwritten.
- reset_i mid-frame returns all registers to reset values immediately. Pending data is discarded.

## Structure
- Package ssd_pkg holds:
  - glyph mode enum (GLYPH_HEX, GLYPH_NOTE)
  - 7-bit constants SSD_BLANK and SSD_DASH
  - the note and hex glyph constant arrays
- Sub-module ssd_glyph: combinational nibble + mode to 7-bit active-low glyph.
- Index width is $clog2(NUM_DIGITS), with a minimum of 1.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, GUARD=1, BLINK_FRAMES=2.
- Reset release, no load -> an_o=4'hF, ssd_o=7'h7F for 64 cycles; load_ready_o=1.
- Load digits 16'h3210, mode note, blank 0 -> from the first boundary, digit 0 shows 0001000 with an_o=4'b1110 for cycles 1..7 of its slot. Cycle 0 of the slot is dark. Digits 1..3 show Bb, B, C in turn.
- Two loads back to back mid-frame -> load_ready_o drops after the first and the second stalls. The first is displayed at the boundary, and the second is accepted on the following cycle.
- Load asserted exactly on a boundary cycle -> new contents are visible in the next slot; load_ready_o stays 1.
- blink=4'b0001 with hex 16'hABCD -> digit 0 ('D', 0100001) is dark on alternate 2-frame periods (64 cycles). Digits 1..3 are unaffected.
- Assert reset_i mid-slot with pending_full=1 -> outputs go dark on the next edge, and pending is discarded (nothing is shown after reset release).
